// File: rtl/fillbox_pkg.sv
// fillbox_pkg
//  Shared types and constants for the fillbox blocks.
//  - state_t      : AXI write master FSM states
//  - SIZE_4B      : awsize for 32-bit beats
//  - BURST_INCR   : incrementing burst type
//  - RESP_OKAY    : AXI OKAY response code
//  - SCREEN_WIDTH : line width in pixels, shared with the X/Y sequencer
`timescale 1ns/1ps
package fillbox_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] SIZE_4B      = 3'b010;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam int         SCREEN_WIDTH = 320;

endpackage

// File: rtl/fillbox_axi_wr.sv
// fillbox_axi_wr
//  AXI4 write master fed by the fillbox X/Y address sequencer. Each
//  burst_start latches one command (address, length, strobe, colour) and
//  runs the AW, W and B channels; every beat carries {color, color}.
//  burst_done pulses for one cycle once the B response is accepted.
// Ports
//  clk, rst          : clock, asynchronous active-high reset
//  color             : RGB565 fill pixel, sampled at burst_start
//  burst_start       : one-cycle command strobe (ignored while busy)
//  awaddr/awlen/wstrb: command byte address (28b), beats-1, byte strobe
//  busy              : a burst is in flight
//  burst_done        : one-cycle pulse on B handshake
//  err               : sticky; clamped awlen or non-OKAY bresp
//  m_axi_aw*/w*/b*   : AXI4 write address, data and response channels
`timescale 1ns/1ps
module fillbox_axi_wr
    import fillbox_pkg::*;
#(
    parameter logic [3:0] ADDR_HI = 4'h1,
    parameter logic [3:0] AXCACHE = 4'b0011,
    parameter logic [7:0] MAX_LEN = 8'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] color,
    input  logic        burst_start,
    input  logic [27:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [3:0]  wstrb,
    output logic        busy,
    output logic        burst_done,
    output logic        err,
    output logic [31:0] m_axi_awaddr,
    output logic [7:0]  m_axi_awlen,
    output logic [2:0]  m_axi_awsize,
    output logic [1:0]  m_axi_awburst,
    output logic [3:0]  m_axi_awcache,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wlast,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    state_t     state;
    logic [7:0] beat_cnt;
    logic       aw_ok;
    logic       w_ok;

    logic [7:0] len_clamped;
    logic       len_over;
    logic [7:0] beat_next;
    logic       aw_done;
    logic       w_done;
    logic       addr_lo_unused;

    // The low address bits are forced to zero, so they are deliberately unused.
    assign addr_lo_unused = ^awaddr[1:0];

    assign len_over    = (awlen > MAX_LEN);
    assign len_clamped = len_over ? MAX_LEN : awlen;
    assign beat_next   = beat_cnt + 8'd1;

    // A channel counts as finished either from an earlier handshake or from
    // one happening this cycle, so AW and W completing together still move on.
    assign aw_done = aw_ok | (m_axi_awvalid & m_axi_awready);
    assign w_done  = w_ok  | (m_axi_wvalid & m_axi_wready & m_axi_wlast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            beat_cnt      <= 8'd0;
            aw_ok         <= 1'b0;
            w_ok          <= 1'b0;
            busy          <= 1'b0;
            burst_done    <= 1'b0;
            err           <= 1'b0;
            m_axi_awaddr  <= 32'd0;
            m_axi_awlen   <= 8'd0;
            m_axi_awsize  <= 3'd0;
            m_axi_awburst <= 2'd0;
            m_axi_awcache <= 4'd0;
            m_axi_awprot  <= 3'd0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= 32'd0;
            m_axi_wstrb   <= 4'd0;
            m_axi_wlast   <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (burst_start) begin
                        m_axi_awaddr  <= {ADDR_HI, awaddr[27:2], 2'b00};
                        m_axi_awlen   <= len_clamped;
                        m_axi_awsize  <= SIZE_4B;
                        m_axi_awburst <= BURST_INCR;
                        m_axi_awcache <= AXCACHE;
                        m_axi_awprot  <= 3'b000;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wdata   <= {color, color};
                        m_axi_wstrb   <= wstrb;
                        m_axi_wlast   <= (len_clamped == 8'd0);
                        m_axi_wvalid  <= 1'b1;
                        beat_cnt      <= 8'd0;
                        aw_ok         <= 1'b0;
                        w_ok          <= 1'b0;
                        busy          <= 1'b1;
                        if (len_over) begin
                            err <= 1'b1;
                        end
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (m_axi_awvalid && m_axi_awready) begin
                        m_axi_awvalid <= 1'b0;
                        aw_ok         <= 1'b1;
                    end
                    if (m_axi_wvalid && m_axi_wready) begin
                        beat_cnt <= beat_next;
                        if (m_axi_wlast) begin
                            m_axi_wvalid <= 1'b0;
                            m_axi_wlast  <= 1'b0;
                            w_ok         <= 1'b1;
                        end else begin
                            // wlast is kept registered: it tracks beat_cnt == len.
                            m_axi_wlast <= (beat_next == m_axi_awlen);
                        end
                    end
                    if (aw_done && w_done) begin
                        m_axi_bready <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        burst_done   <= 1'b1;
                        busy         <= 1'b0;
                        if (m_axi_bresp != RESP_OKAY) begin
                            err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
